operand_issue_stage: RTL and testbench
======================================

// Module: operand_issue_stage
// PURPOSE
//   Register-file and operand-issue stage directly upstream of the 8-bit add/sub ALU.
//   - Accepts a two-register instruction (rd, rs, op) over a valid/ready handshake.
//   - Reads both operands and registers them onto the ALU inputs.
//   - On the following edge, writes the ALU's combinational result back into rd.
//   - Forwards the in-flight result to back-to-back dependent instructions, giving one instruction per cycle.
// PARAMETERS
//   DATA_W  8  operand/result width; must match the ALU width
//   NREG    4  number of architectural registers
//   ADDR_W  2  register address width; NREG == 2**ADDR_W
// PORTS
//   clk          in   1       single clock, rising edge
//   rst_n        in   1       synchronous active-low reset, sampled on rising clk
//   instr_valid  in   1       instruction presented
//   instr_ready  out  1       stage can accept; combinational, equals ~ld_valid
//   instr_rd     in   ADDR_W  destination register and first operand
//   instr_rs     in   ADDR_W  second operand register
//   instr_op     in   1       0: rs+rd, 1: rd-rs; passed to ALU select
//   instr_wb     in   1       1: write result to rd; 0: compare-only, no write
//   alu_rd_data  out  DATA_W  registered operand for ALU rd_data
//   alu_rs_data  out  DATA_W  registered operand for ALU rs_data
//   alu_select   out  1       registered op for ALU select
//   alu_valid    out  1       ALU inputs hold a live instruction this cycle
//   alu_result   in   DATA_W  ALU out, combinational from alu_* ports
//   ld_valid     in   1       external register load (initialisation)
//   ld_addr      in   ADDR_W  load target
//   ld_data      in   DATA_W  load value
//   wb_valid     out  1       registered: a register was written from alu_result last edge
//   wb_addr      out  ADDR_W  registered: register written
//   wb_data      out  DATA_W  registered: value written
//   dbg_addr     in   ADDR_W  debug read address
//   dbg_data     out  DATA_W  combinational regfile[dbg_addr]; no forwarding
// BEHAVIOUR
//   Reset (rst_n=0 at an edge)
//   - All registers, alu_rd_data, alu_rs_data, alu_select, alu_valid, wb_valid, wb_addr and wb_data clear to 0.
//   - An in-flight instruction is dropped and performs no write.
//   Handshake
//   - An instruction is accepted at an edge when instr_valid && instr_ready.
//   - instr_valid low, or ld_valid high, creates a bubble: alu_valid <= 0 at that edge.
//   Issue (accept edge N)
//   - alu_rd_data <= fwd(instr_rd); alu_rs_data <= fwd(instr_rs); alu_select <= instr_op.
//   - alu_valid <= 1; ex_dst <= instr_rd; ex_wb <= instr_wb.
//   Execute / writeback (edge N+1)
//   - Condition: alu_valid && ex_wb.
//   - regfile[ex_dst] <= alu_result; wb_valid <= 1; wb_addr <= ex_dst; wb_data <= alu_result.
//   - Otherwise wb_valid <= 0. Latency: accept to register write = 2 edges.
//   Forwarding
//   - fwd(a) = alu_result if (alu_valid && ex_wb && ex_dst==a), else regfile[a].
//   - Applies independently to each operand, including rd==rs.
//   Load
//   - ld_valid at an edge writes regfile[ld_addr] <= ld_data and blocks issue for that cycle.
//   - A writeback to the same address in the same edge loses: the load wins and wb_valid still reports the dropped write.
//   - Loads to other addresses and the writeback both commit.
//   Arithmetic
//   - The stage never alters data; results are modulo 2**DATA_W as produced by the ALU.
//   - Overflow and borrow are discarded.
//   instr_wb=0
//   - Occupies the ALU slot; no write and no forwarding.
//   - The result is visible only on alu_result during that cycle.
// TESTING
//   1. Reset: drive rst_n=0 for 2 edges -> all outputs 0, dbg_data=0 for every address.
//   2. Load and add: load R1=0x05, R2=0x03; issue add rd=1 rs=2 -> alu_rd_data=05, alu_rs_data=03; next edge wb_valid=1, wb_addr=1, wb_data=0x08.
//   3. Forwarding and wrap: R1=0x08, R2=0x03; back-to-back sub rd=1 rs=2 twice -> second issue uses forwarded 0x05; R1 ends 0x02. Then add R3=0xFF + R0=0x01 -> R3=0x00.
//   4. Borrow and compare: R0=0x02, R1=0x05; sub rd=0 rs=1 wb=1 -> R0=0xFD. Sub with wb=0 -> wb_valid=0, regfile unchanged.
//   5. Load collision: hold instr_valid=1 and assert ld_valid -> instr_ready=0 and a bubble (alu_valid=0). Load R1=0xAA on the same edge as a writeback to R1=0x08 -> R1=0xAA.
//   6. Reset mid-operation: rst_n=0 on the edge after accepting add -> no write; all registers and outputs 0.

Source files
------------

// File: rtl/operand_issue_if.sv
// Bundle of instruction, ALU, load, writeback and debug signals around the
// operand issue stage. The slave side is the stage; the master side is
// whatever drives instructions, loads and the ALU result.
interface operand_issue_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 2
);
   // instruction handshake
   logic              instr_valid;
   logic              instr_ready;
   logic [ADDR_W-1:0] instr_rd;
   logic [ADDR_W-1:0] instr_rs;
   logic              instr_op;
   logic              instr_wb;
   // ALU operand bus and returned result
   logic [DATA_W-1:0] alu_rd_data;
   logic [DATA_W-1:0] alu_rs_data;
   logic              alu_select;
   logic              alu_valid;
   logic [DATA_W-1:0] alu_result;
   // external register load
   logic              ld_valid;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_data;
   // writeback report
   logic              wb_valid;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   // debug read port
   logic [ADDR_W-1:0] dbg_addr;
   logic [DATA_W-1:0] dbg_data;

   modport slave (
      input  instr_valid, instr_rd, instr_rs, instr_op, instr_wb,
      input  alu_result, ld_valid, ld_addr, ld_data, dbg_addr,
      output instr_ready, alu_rd_data, alu_rs_data, alu_select, alu_valid,
      output wb_valid, wb_addr, wb_data, dbg_data
   );

   modport master (
      output instr_valid, instr_rd, instr_rs, instr_op, instr_wb,
      output alu_result, ld_valid, ld_addr, ld_data, dbg_addr,
      input  instr_ready, alu_rd_data, alu_rs_data, alu_select, alu_valid,
      input  wb_valid, wb_addr, wb_data, dbg_data
   );
endinterface

// File: rtl/operand_issue_stage.sv
// Register file and operand issue stage feeding a combinational add/sub ALU.
// Operands are read (with forwarding of the in-flight result) and registered
// onto the ALU inputs; the ALU result is written back into rd one edge later.
module operand_issue_stage #(
   parameter int DATA_W = 8,
   parameter int NREG   = 4,
   parameter int ADDR_W = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   operand_issue_if.slave  bus
);

   logic [DATA_W-1:0] regfile [NREG];

   logic [DATA_W-1:0] alu_rd_data_reg;
   logic [DATA_W-1:0] alu_rs_data_reg;
   logic              alu_select_reg;
   logic              alu_valid_reg;
   logic [ADDR_W-1:0] ex_dst_reg;
   logic              ex_wb_reg;
   logic              wb_valid_reg;
   logic [ADDR_W-1:0] wb_addr_reg;
   logic [DATA_W-1:0] wb_data_reg;

   logic              accept;
   logic              ex_commit;
   logic [DATA_W-1:0] fwd_rd;
   logic [DATA_W-1:0] fwd_rs;
   logic [NREG-1:0]   ld_hit;
   logic [NREG-1:0]   wb_hit;

   // A load owns the register write path this cycle, so it blocks issue.
   assign bus.instr_ready = ~bus.ld_valid;
   assign accept          = bus.instr_valid & ~bus.ld_valid;
   // Only a write-enabled instruction in the ALU slot commits or forwards.
   assign ex_commit       = alu_valid_reg & ex_wb_reg;

   // Per-register write selects for the load and writeback paths.
   for (genvar gi = 0; gi < NREG; gi++) begin : g_hit
      assign ld_hit[gi] = bus.ld_valid && (bus.ld_addr == ADDR_W'(gi));
      assign wb_hit[gi] = ex_commit && (ex_dst_reg == ADDR_W'(gi));
   end

   // Operand read with bypass of the result currently leaving the ALU.
   always_comb begin
      fwd_rd = regfile[bus.instr_rd];
      fwd_rs = regfile[bus.instr_rs];
      if (ex_commit && ex_dst_reg == bus.instr_rd) fwd_rd = bus.alu_result;
      if (ex_commit && ex_dst_reg == bus.instr_rs) fwd_rs = bus.alu_result;
   end

   // Register file update; a load beats a writeback to the same register.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NREG; i++) begin
         if (!rst_n) begin
            regfile[i] <= '0;
         end else if (ld_hit[i]) begin
            regfile[i] <= bus.ld_data;
         end else if (wb_hit[i]) begin
            regfile[i] <= bus.alu_result;
         end
      end
   end

   // Issue: capture operands and op onto the ALU inputs, or insert a bubble.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         alu_rd_data_reg <= '0;
         alu_rs_data_reg <= '0;
         alu_select_reg  <= 1'b0;
         alu_valid_reg   <= 1'b0;
         ex_dst_reg      <= '0;
         ex_wb_reg       <= 1'b0;
      end else if (accept) begin
         alu_rd_data_reg <= fwd_rd;
         alu_rs_data_reg <= fwd_rs;
         alu_select_reg  <= bus.instr_op;
         alu_valid_reg   <= 1'b1;
         ex_dst_reg      <= bus.instr_rd;
         ex_wb_reg       <= bus.instr_wb;
      end else begin
         alu_valid_reg   <= 1'b0;
      end
   end

   // Writeback report; still raised when a same-address load overrode the write.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wb_valid_reg <= 1'b0;
         wb_addr_reg  <= '0;
         wb_data_reg  <= '0;
      end else if (ex_commit) begin
         wb_valid_reg <= 1'b1;
         wb_addr_reg  <= ex_dst_reg;
         wb_data_reg  <= bus.alu_result;
      end else begin
         wb_valid_reg <= 1'b0;
      end
   end

   assign bus.alu_rd_data = alu_rd_data_reg;
   assign bus.alu_rs_data = alu_rs_data_reg;
   assign bus.alu_select  = alu_select_reg;
   assign bus.alu_valid   = alu_valid_reg;
   assign bus.wb_valid    = wb_valid_reg;
   assign bus.wb_addr     = wb_addr_reg;
   assign bus.wb_data     = wb_data_reg;
   assign bus.dbg_data    = regfile[bus.dbg_addr];

endmodule

// File: tb/tb_operand_issue_stage.sv
// Scoreboard bench for operand_issue_stage: issue tasks push expected ALU
// operands and writebacks; a negedge monitor pops and compares them.
module tb_operand_issue_stage;

   typedef struct {
      logic [7:0] rd;
      logic [7:0] rs;
      logic       sel;
   } alu_exp_t;

   typedef struct {
      logic [1:0] addr;
      logic [7:0] data;
   } wb_exp_t;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   alu_exp_t alu_q[$];
   wb_exp_t  wb_q[$];

   operand_issue_if #(.DATA_W(8), .ADDR_W(2)) bus ();

   operand_issue_stage #(.DATA_W(8), .NREG(4), .ADDR_W(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ALU model: combinational add/sub on the registered operands
   assign bus.alu_result = bus.alu_select ? (bus.alu_rd_data - bus.alu_rs_data)
                                          : (bus.alu_rd_data + bus.alu_rs_data);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   // Monitor: compare every live ALU slot and every writeback against the queues
   always @(negedge clk) begin
      if (bus.alu_valid === 1'b1) begin
         if (alu_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL alu_unexpected: got rd=%0h rs=%0h sel=%0b expected no issue",
                     bus.alu_rd_data, bus.alu_rs_data, bus.alu_select);
         end else begin
            alu_exp_t e;
            e = alu_q.pop_front();
            chk("alu_rd_data", 32'(bus.alu_rd_data), 32'(e.rd));
            chk("alu_rs_data", 32'(bus.alu_rs_data), 32'(e.rs));
            chk("alu_select",  32'(bus.alu_select),  32'(e.sel));
         end
      end
      if (bus.wb_valid === 1'b1) begin
         if (wb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL wb_unexpected: got addr=%0h data=%0h expected no writeback",
                     bus.wb_addr, bus.wb_data);
         end else begin
            wb_exp_t w;
            w = wb_q.pop_front();
            chk("wb_addr", 32'(bus.wb_addr), 32'(w.addr));
            chk("wb_data", 32'(bus.wb_data), 32'(w.data));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [1:0] a, input logic [7:0] d);
      bus.ld_valid = 1'b1;
      bus.ld_addr  = a;
      bus.ld_data  = d;
      tick();
      bus.ld_valid = 1'b0;
   endtask

   task automatic issue(input logic [1:0] rd, input logic [1:0] rs, input logic op,
                        input logic wb, input logic [7:0] exp_rd, input logic [7:0] exp_rs,
                        input logic [7:0] exp_res);
      alu_exp_t e;
      wb_exp_t  w;
      e.rd = exp_rd; e.rs = exp_rs; e.sel = op;
      alu_q.push_back(e);
      if (wb) begin
         w.addr = rd; w.data = exp_res;
         wb_q.push_back(w);
      end
      bus.instr_valid = 1'b1;
      bus.instr_rd    = rd;
      bus.instr_rs    = rs;
      bus.instr_op    = op;
      bus.instr_wb    = wb;
      tick();
      bus.instr_valid = 1'b0;
   endtask

   task automatic chk_reg(input string name, input logic [1:0] a, input logic [7:0] exp);
      bus.dbg_addr = a;
      #1;
      chk(name, 32'(bus.dbg_data), 32'(exp));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_alu_valid"},   32'(bus.alu_valid),   32'd0);
      chk({tag, "_alu_rd_data"}, 32'(bus.alu_rd_data), 32'd0);
      chk({tag, "_alu_rs_data"}, 32'(bus.alu_rs_data), 32'd0);
      chk({tag, "_alu_select"},  32'(bus.alu_select),  32'd0);
      chk({tag, "_wb_valid"},    32'(bus.wb_valid),    32'd0);
      chk({tag, "_wb_addr"},     32'(bus.wb_addr),     32'd0);
      chk({tag, "_wb_data"},     32'(bus.wb_data),     32'd0);
      for (int i = 0; i < 4; i++) chk_reg($sformatf("%s_R%0d", tag, i), 2'(i), 8'h00);
   endtask

   // Watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      bus.instr_valid = 1'b0; bus.instr_rd = '0; bus.instr_rs = '0;
      bus.instr_op = 1'b0; bus.instr_wb = 1'b0;
      bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
      bus.dbg_addr = '0;

      // 1. reset
      tick();
      tick();
      chk_all_zero("reset");
      rst_n = 1'b1;
      tick();

      // 2. load and add
      do_load(2'd1, 8'h05);
      do_load(2'd2, 8'h03);
      issue(2'd1, 2'd2, 1'b0, 1'b1, 8'h05, 8'h03, 8'h08);
      tick();
      chk_reg("add_R1", 2'd1, 8'h08);

      // 3. back-to-back dependent subs with forwarding, then wrap on add
      do_load(2'd1, 8'h08);
      do_load(2'd2, 8'h03);
      issue(2'd1, 2'd2, 1'b1, 1'b1, 8'h08, 8'h03, 8'h05);
      issue(2'd1, 2'd2, 1'b1, 1'b1, 8'h05, 8'h03, 8'h02);
      tick();
      chk_reg("fwd_R1", 2'd1, 8'h02);
      do_load(2'd3, 8'hFF);
      do_load(2'd0, 8'h01);
      issue(2'd3, 2'd0, 1'b0, 1'b1, 8'hFF, 8'h01, 8'h00);
      tick();
      chk_reg("wrap_R3", 2'd3, 8'h00);

      // 4. borrow, compare-only (no write, no forward), rd==rs forwarding
      do_load(2'd0, 8'h02);
      do_load(2'd1, 8'h05);
      issue(2'd0, 2'd1, 1'b1, 1'b1, 8'h02, 8'h05, 8'hFD);
      tick();
      chk_reg("borrow_R0", 2'd0, 8'hFD);
      issue(2'd0, 2'd1, 1'b1, 1'b0, 8'hFD, 8'h05, 8'h00);
      issue(2'd1, 2'd0, 1'b0, 1'b1, 8'h05, 8'hFD, 8'h02);
      issue(2'd1, 2'd1, 1'b0, 1'b1, 8'h02, 8'h02, 8'h04);
      tick();
      chk_reg("cmp_R0", 2'd0, 8'hFD);
      chk_reg("same_R1", 2'd1, 8'h04);

      // 5. load blocks issue and wins a same-address collision
      do_load(2'd1, 8'h05);
      do_load(2'd2, 8'h03);
      issue(2'd1, 2'd2, 1'b0, 1'b1, 8'h05, 8'h03, 8'h08);
      bus.instr_valid = 1'b1;
      bus.instr_rd = 2'd2; bus.instr_rs = 2'd2; bus.instr_op = 1'b0; bus.instr_wb = 1'b1;
      bus.ld_valid = 1'b1; bus.ld_addr = 2'd1; bus.ld_data = 8'hAA;
      #1;
      chk("ld_instr_ready", 32'(bus.instr_ready), 32'd0);
      tick();
      chk("ld_bubble_alu_valid", 32'(bus.alu_valid), 32'd0);
      bus.instr_valid = 1'b0;
      bus.ld_valid = 1'b0;
      tick();
      chk_reg("collide_R1", 2'd1, 8'hAA);
      chk_reg("collide_R2", 2'd2, 8'h03);

      // 6. reset while an add is in flight
      do_load(2'd0, 8'h07);
      issue(2'd0, 2'd0, 1'b0, 1'b1, 8'h07, 8'h07, 8'h0E);
      void'(wb_q.pop_back());   // this write must never appear
      rst_n = 1'b0;
      tick();
      chk_all_zero("midrst");
      rst_n = 1'b1;
      tick();
      tick();

      chk("alu_queue_drained", 32'(alu_q.size()), 32'd0);
      chk("wb_queue_drained",  32'(wb_q.size()),  32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
